// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the byte-serial memory access sequencer.
// Holds the FSM state encoding, the request size codes and the legality rule for a request.
package mem_seq_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam int         NUM_LANES = 4;

    // Only byte accesses and naturally aligned word accesses are served.
    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        return !((size == SIZE_BYTE) || ((size == SIZE_WORD) && (addr_lo == 2'b00)));
    endfunction

endpackage

// File: rtl/mem_access_sequencer_load_extend.sv
// Turns the assembled load lanes into the core-facing result.
// A word passes through unchanged; a byte is zero- or sign-extended from lane 0.
module load_extend
    import mem_seq_pkg::*;
(
    input  logic [31:0] i_bytes,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    logic w_fill;

    assign w_fill = i_bytes[7] & i_signed;
    assign o_data = (i_size == SIZE_WORD) ? i_bytes : {{24{w_fill}}, i_bytes[7:0]};

endmodule

// File: rtl/mem_access_sequencer.sv
// Multi-cycle load/store sequencer in front of a single-port, byte-wide data memory.
// Each access is split into byte beats; done pulses for one cycle when the access retires.
module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [7:0]            mem_rdata
);

    localparam int              LAT_W    = $clog2(RD_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LATENCY - 1);

    state_t                        r_state;
    state_t                        w_state_next;
    logic                          r_write;
    logic                          r_signed;
    logic                          r_err;
    logic [1:0]                    r_size;
    logic [ADDR_WIDTH-1:0]         r_addr;
    logic [DATA_WIDTH-1:0]         r_wdata;
    logic [1:0]                    r_beat;
    logic [LAT_W-1:0]              r_lat;
    logic [NUM_LANES-1:0][7:0]     r_lanes;
    logic [DATA_WIDTH-1:0]         r_rdata;
    logic [ADDR_WIDTH-1:0]         r_mem_addr;
    logic [7:0]                    r_mem_wdata;

    logic                          w_illegal;
    logic                          w_last_beat;
    logic                          w_lat_done;
    logic [1:0]                    w_beat_next;
    logic [ADDR_WIDTH-1:0]         w_addr_next;
    logic [7:0]                    w_wbyte_next;
    logic [NUM_LANES-1:0][7:0]     w_lanes_cap;
    logic [DATA_WIDTH-1:0]         w_ext;

    assign w_illegal    = is_illegal(req_size, req_addr[1:0]);
    assign w_last_beat  = (r_size == SIZE_WORD) ? (r_beat == 2'd3) : 1'b1;
    assign w_lat_done   = (r_lat == LAT_LAST);
    assign w_beat_next  = r_beat + 2'd1;
    assign w_addr_next  = r_addr + ADDR_WIDTH'(w_beat_next);
    assign w_wbyte_next = r_wdata[{w_beat_next, 3'b000} +: 8];

    // The byte arriving this cycle is merged in so a final beat can retire straight to DONE.
    always_comb begin
        w_lanes_cap         = r_lanes;
        w_lanes_cap[r_beat] = mem_rdata;
    end

    load_extend u_load_extend (
        .i_bytes  (w_lanes_cap),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_data   (w_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: every combinational output gets a default before the case so no path infers a latch.
        w_state_next = r_state;
        case (r_state)
            IDLE:  if (req_valid) w_state_next = w_illegal ? DONE : ISSUE;
            ISSUE: begin
                if (!r_write)         w_state_next = WAIT;
                else if (w_last_beat) w_state_next = DONE;
            end
            WAIT:  if (w_lat_done) w_state_next = w_last_beat ? DONE : ISSUE;
            DONE:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign req_ready = (r_state == IDLE);
    assign mem_we    = (r_state == ISSUE) &&  r_write;
    assign mem_re    = (r_state == ISSUE) && !r_write;
    assign done      = (r_state == DONE);
    assign err       = (r_state == DONE) && r_err;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign rdata     = r_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write     <= 1'b0;
            r_signed    <= 1'b0;
            r_err       <= 1'b0;
            r_size      <= SIZE_BYTE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_beat      <= '0;
            r_lat       <= '0;
            r_lanes     <= '0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            case (r_state)
                IDLE: if (req_valid) begin
                    r_write  <= req_write;
                    r_signed <= req_signed;
                    r_size   <= req_size;
                    r_addr   <= req_addr;
                    r_wdata  <= req_wdata;
                    r_err    <= w_illegal;
                    r_beat   <= '0;
                    r_lat    <= '0;
                    if (!w_illegal) begin
                        r_mem_addr <= req_addr;
                        if (req_write) r_mem_wdata <= req_wdata[7:0];
                    end
                end
                ISSUE: begin
                    r_lat <= '0;
                    if (r_write && !w_last_beat) begin
                        r_beat      <= w_beat_next;
                        r_mem_addr  <= w_addr_next;
                        r_mem_wdata <= w_wbyte_next;
                    end
                end
                WAIT: begin
                    if (w_lat_done) begin
                        r_lanes <= w_lanes_cap;
                        if (w_last_beat) begin
                            r_rdata <= w_ext;
                        end else begin
                            r_beat     <= w_beat_next;
                            r_mem_addr <= w_addr_next;
                        end
                    end else begin
                        r_lat <= r_lat + LAT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
